tag_bank_2way: RTL and testbench

// - Two-way set-associative tag store for the cache datapath. Holds tag, valid and LRU state per set.
// - On each lookup it returns both way tags, hit/miss, the hit way and the victim way, all registered.
// - tag_way0/tag_way1/sel_way drive the A/B/SEL inputs of the downstream 2:1 tag-bank mux directly.
// - Also accepts miss fills and performs a sequential full flush.

---
 rtl/cache_pkg.sv | 15 +
 rtl/tag_way_array.sv | 50 +++++
 rtl/tag_bank_2way.sv | 148 ++++++++++++++
 tb/tb_tag_bank_2way.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the two-way tag bank.
package cache_pkg;

    localparam int TAG_W_DEF    = 4;
    localparam int SET_BITS_DEF = 3;

    typedef logic [TAG_W_DEF-1:0]    tag_t;
    typedef logic [SET_BITS_DEF-1:0] set_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bank_state_e;

endpackage

// File: rtl/tag_way_array.sv
// One way of the tag store: tag memory plus per-set valid bits.
// Reads are asynchronous, so a same-cycle write is seen only after the edge.
module tag_way_array
    import cache_pkg::*;
#(
    parameter int TAG_W    = TAG_W_DEF,
    parameter int SET_BITS = SET_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] rd_set,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [SET_BITS-1:0] wr_set,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                clr_en,
    input  logic [SET_BITS-1:0] clr_set
);

    localparam int SETS = 1 << SET_BITS;

    logic [TAG_W-1:0] tag_mem [SETS];
    logic [SETS-1:0]  valid_q;

    // Tag storage: no reset, contents are meaningless while the set is invalid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_set] <= wr_tag;
        end
    end

    // Valid bits: cleared by reset or by index during a flush, set by a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clr_en) begin
                valid_q[clr_set] <= 1'b0;
            end
            if (wr_en) begin
                valid_q[wr_set] <= 1'b1;
            end
        end
    end

    assign rd_tag   = tag_mem[rd_set];
    assign rd_valid = valid_q[rd_set];

endmodule

// File: rtl/tag_bank_2way.sv
// Two-way set-associative tag bank: registered lookup response, miss fills,
// LRU tracking and a sequential flush of all sets.
//
// Handshake: a request (lookup or fill) is taken on a rising edge where its
// valid and the matching ready are both 1 and flush_req is 0; ready depends
// only on state, and a requester that sees ready=0 keeps its request asserted.
module tag_bank_2way
    import cache_pkg::*;
#(
    parameter int TAG_W    = TAG_W_DEF,
    parameter int SET_BITS = SET_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lookup_valid,
    output logic                lookup_ready,
    input  logic [SET_BITS-1:0] lookup_set,
    input  logic [TAG_W-1:0]    lookup_tag,
    output logic                resp_valid,
    output logic                hit,
    output logic                sel_way,
    output logic [TAG_W-1:0]    tag_way0,
    output logic [TAG_W-1:0]    tag_way1,
    input  logic                fill_valid,
    output logic                fill_ready,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic                fill_way,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic                flush_req,
    output logic                busy,
    output bank_state_e         state_dbg
);

    localparam int SETS = 1 << SET_BITS;

    bank_state_e         state_q;
    logic [SET_BITS-1:0] cnt_q;
    logic [SETS-1:0]     lru_q;

    logic [TAG_W-1:0] rd_tag0, rd_tag1;
    logic             rd_valid0, rd_valid1;
    logic             accept_lookup, accept_fill;
    logic             match0, match1, hit_c, hit_way, victim_way, sel_c;
    logic             clr_en;

    assign lookup_ready = (state_q == IDLE);
    assign fill_ready   = (state_q == IDLE);
    assign busy         = (state_q == FLUSH);
    assign state_dbg    = state_q;
    assign clr_en       = (state_q == FLUSH);

    // A flush request in IDLE pre-empts any lookup or fill in the same cycle.
    assign accept_lookup = lookup_valid & lookup_ready & ~flush_req;
    assign accept_fill   = fill_valid & fill_ready & ~flush_req;

    tag_way_array #(.TAG_W(TAG_W), .SET_BITS(SET_BITS)) u_way0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_set   (lookup_set),
        .rd_tag   (rd_tag0),
        .rd_valid (rd_valid0),
        .wr_en    (accept_fill & ~fill_way),
        .wr_set   (fill_set),
        .wr_tag   (fill_tag),
        .clr_en   (clr_en),
        .clr_set  (cnt_q)
    );

    tag_way_array #(.TAG_W(TAG_W), .SET_BITS(SET_BITS)) u_way1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_set   (lookup_set),
        .rd_tag   (rd_tag1),
        .rd_valid (rd_valid1),
        .wr_en    (accept_fill & fill_way),
        .wr_set   (fill_set),
        .wr_tag   (fill_tag),
        .clr_en   (clr_en),
        .clr_set  (cnt_q)
    );

    // Hit detection (way 0 wins a double match) and victim choice
    // (first invalid way, otherwise the LRU way).
    always_comb begin
        match0     = rd_valid0 & (rd_tag0 == lookup_tag);
        match1     = rd_valid1 & (rd_tag1 == lookup_tag);
        hit_c      = match0 | match1;
        hit_way    = ~match0;
        victim_way = !rd_valid0 ? 1'b0 : (!rd_valid1 ? 1'b1 : lru_q[lookup_set]);
        sel_c      = hit_c ? hit_way : victim_way;
    end

    // Control FSM: flush sequencing plus LRU updates; a fill's LRU write
    // comes last so it overrides a same-set hit update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lru_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q <= FLUSH;
                        cnt_q   <= '0;
                    end else begin
                        if (accept_lookup && hit_c) begin
                            lru_q[lookup_set] <= ~hit_way;
                        end
                        if (accept_fill) begin
                            lru_q[fill_set] <= ~fill_way;
                        end
                    end
                end
                FLUSH: begin
                    lru_q[cnt_q] <= 1'b0;
                    cnt_q        <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response registers: pulse resp_valid for an accepted lookup, hold fields otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            sel_way    <= 1'b0;
            tag_way0   <= '0;
            tag_way1   <= '0;
        end else begin
            resp_valid <= accept_lookup;
            if (accept_lookup) begin
                hit      <= hit_c;
                sel_way  <= sel_c;
                tag_way0 <= rd_tag0;
                tag_way1 <= rd_tag1;
            end
        end
    end

endmodule

// File: tb/tb_tag_bank_2way.sv
// Directed bench for tag_bank_2way: lookups, fills, LRU, collisions, flush, reset.
module tb_tag_bank_2way;
    import cache_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [2:0]  lookup_set;
    logic [3:0]  lookup_tag;
    logic        resp_valid;
    logic        hit;
    logic        sel_way;
    logic [3:0]  tag_way0;
    logic [3:0]  tag_way1;
    logic        fill_valid;
    logic        fill_ready;
    logic [2:0]  fill_set;
    logic        fill_way;
    logic [3:0]  fill_tag;
    logic        flush_req;
    logic        busy;
    bank_state_e state_dbg;

    int checks;
    int failures;

    tag_bank_2way #(.TAG_W(4), .SET_BITS(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_set   (lookup_set),
        .lookup_tag   (lookup_tag),
        .resp_valid   (resp_valid),
        .hit          (hit),
        .sel_way      (sel_way),
        .tag_way0     (tag_way0),
        .tag_way1     (tag_way1),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_set     (fill_set),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .flush_req    (flush_req),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle lookup; afterwards the response registers are visible.
    task automatic do_lookup(input logic [2:0] s, input logic [3:0] t);
        lookup_valid = 1'b1;
        lookup_set   = s;
        lookup_tag   = t;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [2:0] s, input logic w, input logic [3:0] t);
        fill_valid = 1'b1;
        fill_set   = s;
        fill_way   = w;
        fill_tag   = t;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, hit, sel_way, tag_way0, tag_way1} !== 11'b0) begin
            $display("FAIL reset_outputs got=%b exp=0", {resp_valid, hit, sel_way, tag_way0, tag_way1});
            failures++;
        end
        checks++;
        if ({lookup_ready, fill_ready, busy, state_dbg} !== {1'b1, 1'b1, 1'b0, IDLE}) begin
            $display("FAIL reset_ctrl got=%b exp=1100", {lookup_ready, fill_ready, busy, state_dbg});
            failures++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_miss_empty();
        do_lookup(3'd3, 4'hA);
        checks++;
        if ({resp_valid, hit, sel_way} !== 3'b100) begin
            $display("FAIL miss_empty got=%b exp=100", {resp_valid, hit, sel_way});
            failures++;
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL resp_pulse got=%b exp=0", resp_valid);
            failures++;
        end
    endtask

    task automatic test_fill_hit();
        do_fill(3'd3, 1'b0, 4'hA);
        checks++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL fill_no_resp got=%b exp=0", resp_valid);
            failures++;
        end
        do_lookup(3'd3, 4'hA);
        checks++;
        if ({resp_valid, hit, sel_way, tag_way0} !== {3'b110, 4'hA}) begin
            $display("FAIL fill_hit got=%b exp=%b", {resp_valid, hit, sel_way, tag_way0}, {3'b110, 4'hA});
            failures++;
        end
    endtask

    task automatic test_lru();
        do_fill(3'd3, 1'b1, 4'h5);     // lru[3] <= 0
        do_lookup(3'd3, 4'hA);          // hit way 0, lru[3] <= 1
        checks++;
        if ({hit, sel_way} !== 2'b10) begin
            $display("FAIL lru_hit_a got=%b exp=10", {hit, sel_way});
            failures++;
        end
        do_lookup(3'd3, 4'h7);
        checks++;
        if ({resp_valid, hit, sel_way, tag_way0, tag_way1} !== {3'b101, 4'hA, 4'h5}) begin
            $display("FAIL lru_victim1 got=%b exp=%b", {resp_valid, hit, sel_way, tag_way0, tag_way1},
                     {3'b101, 4'hA, 4'h5});
            failures++;
        end
        do_lookup(3'd3, 4'h5);          // hit way 1, lru[3] <= 0
        checks++;
        if ({hit, sel_way} !== 2'b11) begin
            $display("FAIL lru_hit_5 got=%b exp=11", {hit, sel_way});
            failures++;
        end
        do_lookup(3'd3, 4'h7);
        checks++;
        if ({hit, sel_way} !== 2'b00) begin
            $display("FAIL lru_victim0 got=%b exp=00", {hit, sel_way});
            failures++;
        end
    endtask

    task automatic test_same_cycle();
        // Same set: lookup sees pre-fill contents.
        lookup_valid = 1'b1; lookup_set = 3'd2; lookup_tag = 4'h9;
        fill_valid = 1'b1;   fill_set = 3'd2;   fill_way = 1'b0; fill_tag = 4'h9;
        tick();
        lookup_valid = 1'b0; fill_valid = 1'b0;
        checks++;
        if ({resp_valid, hit, sel_way} !== 3'b100) begin
            $display("FAIL rbw_first got=%b exp=100", {resp_valid, hit, sel_way});
            failures++;
        end
        do_lookup(3'd2, 4'h9);
        checks++;
        if ({resp_valid, hit, sel_way} !== 3'b110) begin
            $display("FAIL rbw_second got=%b exp=110", {resp_valid, hit, sel_way});
            failures++;
        end
        // Same set, fill LRU overrides hit LRU: hit way 0 wants lru=1, fill way 1 forces lru=0.
        lookup_valid = 1'b1; lookup_set = 3'd3; lookup_tag = 4'hA;
        fill_valid = 1'b1;   fill_set = 3'd3;   fill_way = 1'b1; fill_tag = 4'h5;
        tick();
        lookup_valid = 1'b0; fill_valid = 1'b0;
        checks++;
        if ({hit, sel_way} !== 2'b10) begin
            $display("FAIL override_hit got=%b exp=10", {hit, sel_way});
            failures++;
        end
        do_lookup(3'd3, 4'h7);
        checks++;
        if ({hit, sel_way} !== 2'b00) begin
            $display("FAIL override_lru got=%b exp=00", {hit, sel_way});
            failures++;
        end
        // Different sets: lookup hit in set 3, fill into set 4.
        lookup_valid = 1'b1; lookup_set = 3'd3; lookup_tag = 4'h5;
        fill_valid = 1'b1;   fill_set = 3'd4;   fill_way = 1'b1; fill_tag = 4'hC;
        tick();
        lookup_valid = 1'b0; fill_valid = 1'b0;
        checks++;
        if ({hit, sel_way} !== 2'b11) begin
            $display("FAIL diff_set_hit got=%b exp=11", {hit, sel_way});
            failures++;
        end
        do_lookup(3'd4, 4'hC);
        checks++;
        if ({hit, sel_way, tag_way1} !== {2'b11, 4'hC}) begin
            $display("FAIL diff_set_fill got=%b exp=%b", {hit, sel_way, tag_way1}, {2'b11, 4'hC});
            failures++;
        end
    endtask

    task automatic test_flush();
        int n;
        logic [3:0] tags [8];
        tags[0] = 4'hA; tags[1] = 4'h5; tags[2] = 4'h9; tags[3] = 4'hA;
        tags[4] = 4'hC; tags[5] = 4'h5; tags[6] = 4'hE; tags[7] = 4'h9;
        // Flush pre-empts a same-cycle lookup.
        flush_req = 1'b1;
        lookup_valid = 1'b1; lookup_set = 3'd3; lookup_tag = 4'hA;
        tick();
        flush_req = 1'b0; lookup_valid = 1'b0;
        checks++;
        if ({resp_valid, busy} !== 2'b01) begin
            $display("FAIL flush_drop got=%b exp=01", {resp_valid, busy});
            failures++;
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            checks++;
            if ({lookup_ready, fill_ready} !== 2'b00) begin
                $display("FAIL flush_ready cyc=%0d got=%b exp=00", n, {lookup_ready, fill_ready});
                failures++;
            end
            // A fill offered early in the flush must never land; a repeated flush_req is ignored.
            fill_valid = (n < 4); fill_set = 3'd6; fill_way = 1'b0; fill_tag = 4'hE;
            flush_req  = (n == 2);
            n++;
            tick();
        end
        fill_valid = 1'b0; flush_req = 1'b0;
        checks++;
        if (n != 8) begin
            $display("FAIL flush_len got=%0d exp=8", n);
            failures++;
        end
        for (int s = 0; s < 8; s++) begin
            do_lookup(3'(s), tags[s]);
            checks++;
            if ({resp_valid, hit, sel_way} !== 3'b100) begin
                $display("FAIL post_flush set=%0d got=%b exp=100", s, {resp_valid, hit, sel_way});
                failures++;
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        do_fill(3'd7, 1'b0, 4'hB);
        do_lookup(3'd7, 4'hB);
        checks++;
        if ({hit, sel_way} !== 2'b10) begin
            $display("FAIL prefill_hit got=%b exp=10", {hit, sel_way});
            failures++;
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL midflush_busy got=%b exp=1", busy);
            failures++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, lookup_ready, state_dbg} !== {1'b0, 1'b1, IDLE}) begin
            $display("FAIL midflush_reset got=%b exp=010", {busy, lookup_ready, state_dbg});
            failures++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_lookup(3'd7, 4'hB);
        checks++;
        if ({resp_valid, hit, sel_way, busy} !== 4'b1000) begin
            $display("FAIL midflush_set7 got=%b exp=1000", {resp_valid, hit, sel_way, busy});
            failures++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        lookup_valid = 1'b0; lookup_set = '0; lookup_tag = '0;
        fill_valid = 1'b0;   fill_set = '0;   fill_way = 1'b0; fill_tag = '0;
        flush_req = 1'b0;
        test_reset();
        test_miss_empty();
        test_fill_hit();
        test_lru();
        test_same_cycle();
        test_flush();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
